// File: rtl/dcache_axi_bridge.sv
// -----------------------------------------------------------------------------
// dcache_axi_bridge
//   Memory-side responder for the data cache's line refill / write-back port.
//   Each request moves one whole cache line as a single AXI4 INCR burst. When
//   the burst finishes, gnt pulses for one cycle. Refill data stays registered
//   on rd_data until the next refill overwrites it.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_addr            line address from the cache (bits [4:0] ignored)
//   rd_req / wr_req     refill / write-back request levels, held until gnt
//   wr_data             write-back line, word i = byte offset 4*i
//   rd_data             registered refill line
//   gnt                 one-cycle completion pulse
//   ar* / r*            AXI read address and read data channels
//   aw* / w* / b*       AXI write address, write data and write response
// -----------------------------------------------------------------------------
module dcache_axi_bridge #(
   parameter int unsigned LINE_WORDS = 8,
   parameter logic [3:0]  AXI_ID     = 4'd1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  req_addr,
   input  logic                         rd_req,
   input  logic                         wr_req,
   input  logic [LINE_WORDS-1:0][31:0]  wr_data,
   output logic [LINE_WORDS-1:0][31:0]  rd_data,
   output logic                         gnt,
   output logic [3:0]                   arid,
   output logic [31:0]                  araddr,
   output logic [7:0]                   arlen,
   output logic [2:0]                   arsize,
   output logic [1:0]                   arburst,
   output logic                         arvalid,
   input  logic                         arready,
   input  logic [31:0]                  rdata,
   input  logic                         rvalid,
   input  logic                         rlast,
   output logic                         rready,
   output logic [3:0]                   awid,
   output logic [31:0]                  awaddr,
   output logic [7:0]                   awlen,
   output logic [2:0]                   awsize,
   output logic [1:0]                   awburst,
   output logic                         awvalid,
   input  logic                         awready,
   output logic [31:0]                  wdata,
   output logic [3:0]                   wstrb,
   output logic                         wlast,
   output logic                         wvalid,
   input  logic                         wready,
   input  logic                         bvalid,
   output logic                         bready
);

   localparam int unsigned   BW        = $clog2(LINE_WORDS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RADDR,
      S_RDATA,
      S_WADDR,
      S_WDATA,
      S_WRESP,
      S_DONE
   } state_t;

   state_t                       r_state;
   state_t                       w_next;
   logic [BW-1:0]                r_beat;
   logic [31:0]                  r_line_addr;
   logic [LINE_WORDS-1:0][31:0]  r_wr_line;
   logic [LINE_WORDS-1:0][31:0]  r_rd_data;

   // ---------------------------------------------------------------------
   // State register, beat counter and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_beat    <= '0;
         r_rd_data <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               // Snapshot the request so the cache may change its inputs freely
               if (wr_req || rd_req) begin
                  r_line_addr <= req_addr & 32'hFFFF_FFE0;
                  r_wr_line   <= wr_data;
               end
            end
            S_RADDR: if (arready) r_beat <= '0;
            S_RDATA: begin
               if (rvalid) begin
                  r_rd_data[r_beat] <= rdata;
                  r_beat            <= r_beat + 1'b1;
               end
            end
            S_WADDR: if (awready) r_beat <= '0;
            S_WDATA: if (wready)  r_beat <= r_beat + 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Next state and Moore channel controls
   // ---------------------------------------------------------------------
   always_comb begin
      w_next  = r_state;
      arvalid = 1'b0;
      rready  = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      wlast   = 1'b0;
      bready  = 1'b0;
      gnt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Write-back wins so a dirty victim leaves before its refill lands
            if (wr_req)      w_next = S_WADDR;
            else if (rd_req) w_next = S_RADDR;
         end
         S_RADDR: begin
            arvalid = 1'b1;
            if (arready) w_next = S_RDATA;
         end
         S_RDATA: begin
            rready = 1'b1;
            // An early rlast from the slave also closes the burst
            if (rvalid && (rlast || (r_beat == LAST_BEAT))) w_next = S_DONE;
         end
         S_WADDR: begin
            awvalid = 1'b1;
            if (awready) w_next = S_WDATA;
         end
         S_WDATA: begin
            wvalid = 1'b1;
            wlast  = (r_beat == LAST_BEAT);
            if (wready && (r_beat == LAST_BEAT)) w_next = S_WRESP;
         end
         S_WRESP: begin
            bready = 1'b1;
            if (bvalid) w_next = S_DONE;
         end
         S_DONE: begin
            gnt    = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Burst attributes and datapath outputs
   // ---------------------------------------------------------------------
   assign arid    = AXI_ID;
   assign awid    = AXI_ID;
   assign araddr  = r_line_addr;
   assign awaddr  = r_line_addr;
   assign arlen   = 8'(LINE_WORDS - 1);
   assign awlen   = 8'(LINE_WORDS - 1);
   assign arsize  = 3'b010;
   assign awsize  = 3'b010;
   assign arburst = 2'b01;
   assign awburst = 2'b01;
   assign wstrb   = 4'hF;
   assign wdata   = r_wr_line[r_beat];
   assign rd_data = r_rd_data;

endmodule

// File: doc/dcache_axi_bridge.md
Name: dcache_axi_bridge

Overview:
- Memory-side responder for the data cache's line-refill/write-back request interface.
- Accepts one 8-word (32-byte) line request at a time: write-back on `wr_req`, refill on `rd_req`.
- Performs it as a single AXI4 INCR burst and pulses `gnt` when the transfer completes.
- Sits between the data cache and the top-level AXI interconnect; refill data is held stable after `gnt` for the cache's fill cycle.

Parameters:
- LINE_WORDS, 8, words per cache line (burst length is LINE_WORDS-1 encoded).
- AXI_ID, 4'd1, constant ID driven on `arid`/`awid`.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_addr  in  32  line address from cache; bits [4:0] are ignored and forced to 0 on AXI
- rd_req  in  1  refill request; level, held until `gnt`
- wr_req  in  1  write-back request; level, held until `gnt`
- wr_data  in  8x32  write-back line, word i = byte offset 4*i
- rd_data  out  8x32  refill line, registered
- gnt  out  1  one-cycle completion pulse
- arid/awid  out  4  = AXI_ID
- araddr/awaddr  out  32  {req_addr[31:5],5'b0}
- arlen/awlen  out  8  = LINE_WORDS-1
- arsize/awsize  out  3  = 3'b010
- arburst/awburst  out  2  = 2'b01
- arvalid, arready  out, in  1  AR handshake
- rdata  in  32;  rvalid  in  1;  rlast  in  1;  rready  out  1
- awvalid, awready  out, in  1  AW handshake
- wdata  out  32;  wstrb  out  4 (=4'hF);  wlast  out  1;  wvalid  out  1;  wready  in  1
- bvalid  in  1;  bready  out  1

Behaviour:
- Reset values: state IDLE, beat counter 0, `rd_data` all 0, and all of the following at 0: `gnt`, `arvalid`, `rready`, `awvalid`, `wvalid`, `wlast`, `bready`.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
- IDLE:
  - `wr_req` -> WADDR. `wr_req` has priority if both requests are high.
  - otherwise `rd_req` -> RADDR.
  - `req_addr` and `wr_data` are captured into internal registers on leaving IDLE; later changes on the inputs are ignored.
- RADDR: `arvalid`=1 and address stable until `arready`; then -> RDATA with beat=0.
- RDATA:
  - `rready`=1. Each `rvalid` beat writes `rd_data[beat]` and increments beat.
  - The beat with `rlast`=1, or beat==LINE_WORDS-1, -> DONE. Whichever comes first ends the burst.
  - `rresp` is not checked.
- WADDR: `awvalid`=1 until `awready`; then -> WDATA with beat=0.
  - AW and W are sequential; no W is issued before AW completes.
- WDATA:
  - `wvalid`=1 and `wdata` = captured word[beat].
  - `wlast`=1 when beat==LINE_WORDS-1.
  - beat advances only on `wvalid`&`wready`. The last handshake -> WRESP.
- WRESP: `bready`=1; `bvalid` -> DONE. `bresp` is ignored.
- DONE: `gnt`=1 for exactly this one cycle (Moore output); -> IDLE unconditionally.
- A request still high in the cycle after DONE is treated as a new request.
- Latency:
  - refill = 1 (IDLE) + AR wait + 8 beats + 1 (DONE) cycles minimum: `gnt` appears 11 cycles after the request with zero-wait slave.
  - write-back minimum = 1 + 1 + 8 + 1 + 1 = 12 cycles.
- `rd_data` holds its last refill value indefinitely. It is unchanged by write-backs and updated only in RDATA.
- Beat counter: 3 bits, wraps only via reset to 0 on entering RDATA/WDATA.
- `rst` mid-burst: returns to IDLE next cycle and all valids/readies drop. The AXI transaction is abandoned; the system reset covers the slave. `gnt` is never issued for the aborted request.
- No request in IDLE: all AXI valid/ready outputs stay 0.

Test Plan:
- Refill, zero-wait slave: `rd_req`, `req_addr`=0x1FC0_0024; slave returns 0xA0..0xA7 with `rlast` on beat 7 -> `araddr`=0x1FC0_0020, `arlen`=7, `gnt` single pulse 11 cycles after request, `rd_data[i]`=0xA0+i and held after `gnt`.
- Write-back with W backpressure: `wr_req`, `wr_data[i]`=0x100+i; `wready` low every other cycle -> 8 beats in order, `wlast` only with 0x107, `wstrb`=F, `gnt` only after `bvalid`.
- Simultaneous `rd_req`&`wr_req` -> AW issued first, no AR until after `gnt`.
- Back-to-back: after write-back `gnt`, cache raises `rd_req` next cycle -> new AR within 1 cycle of IDLE. Address change on `req_addr` during the burst has no effect on `araddr`/`awaddr`.
- Early `rlast` on beat 3 -> DONE; `rd_data[4..7]` retain previous values; `gnt` pulses once.
- `rst` asserted during RDATA beat 4 -> next cycle IDLE, `rready`=0, no `gnt`; a subsequent refill completes normally.
